gate_array_pipe: RTL and testbench

// - Parametrised successor to the fixed 4-bit NAND gate array.
// - Bitwise gate array of WIDTH bits. Operation is selectable per transaction.
// - Result passes through a STAGES-deep register pipeline with valid/ready backpressure.
// - Sits between operand sources and downstream consumers in the logic datapath.

---
 rtl/gate_array_pipe.sv | 104 ++++++++++
 tb/tb_gate_array_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_array_pipe.sv
// rtl/gate_array_pipe.sv - bitwise gate array feeding a STAGES-deep valid/ready register pipeline
// Optional parity output port is enabled by defining GATE_ARRAY_PARITY_EN.
module gate_array_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic [CNT_W-1:0] tx_count
`ifdef GATE_ARRAY_PARITY_EN
    ,
    output logic             parity
`endif
);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] rdy;
    logic [WIDTH-1:0]  d [STAGES];
    logic [WIDTH-1:0]  f;

    always_comb begin
        f = '0;
        case (op)
            3'b000:  f = a & b;
            3'b001:  f = a | b;
            3'b010:  f = ~(a & b);
            3'b011:  f = ~(a | b);
            3'b100:  f = a ^ b;
            3'b101:  f = ~(a ^ b);
            3'b110:  f = ~a;
            default: f = a;
        endcase
    end

    // A stage may load whenever the output drains or any stage at or after it is empty.
    for (genvar k = 0; k < STAGES; k++) begin : g_rdy
        assign rdy[k] = out_ready | ~(&v[STAGES-1:k]);
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[STAGES-1];
    assign y         = d[STAGES-1];
    assign zero      = v[STAGES-1] & ~(|d[STAGES-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            v        <= '0;
            tx_count <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    d[0] <= f;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        d[k] <= d[k-1];
                    end
                end
            end
            if (v[STAGES-1] && out_ready) begin
                tx_count <= tx_count + CNT_W'(1);
            end
        end
    end

`ifdef GATE_ARRAY_PARITY_EN
    logic [STAGES-1:0] p;

    assign parity = p[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
        end else begin
            if (rdy[0] && in_valid) begin
                p[0] <= ^f;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k] && v[k-1]) begin
                    p[k] <= p[k-1];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_gate_array_pipe.sv
// tb/tb_gate_array_pipe.sv - randomized scoreboard bench for gate_array_pipe (WIDTH=4, STAGES=2, CNT_W=8)
// Parity checks are included when GATE_ARRAY_PARITY_EN is defined.
module tb_gate_array_pipe;

    localparam int WIDTH  = 4;
    localparam int STAGES = 2;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op = '0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic [CNT_W-1:0] tx_count;
`ifdef GATE_ARRAY_PARITY_EN
    logic             parity;
`endif

    gate_array_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .tx_count  (tx_count)
`ifdef GATE_ARRAY_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Per-op truth table indexed by {a_bit, b_bit}.
    logic [3:0] truth [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                              4'b0110, 4'b1001, 4'b0011, 4'b1100};

    function automatic logic [WIDTH-1:0] model_f(input logic [2:0] o,
                                                 input logic [WIDTH-1:0] aa,
                                                 input logic [WIDTH-1:0] bb);
        logic [WIDTH-1:0] r;
        logic [3:0]       t;
        t = truth[o];
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = t[{aa[i], bb[i]}];
        end
        return r;
    endfunction

    typedef struct {
        logic [WIDTH-1:0] y;
        int               t;
        bit               lit_en;
        logic [WIDTH-1:0] lit;
    } ent_t;

    ent_t             q[$];
    ent_t             e;
    int               cyc = 0;
    int               cnt = 0;
    bit               chk_en = 1'b0;
    bit               lit_en = 1'b0;
    logic [WIDTH-1:0] lit_val = '0;
    bit               exp_ir;
    bit               exp_ov;

    // Scoreboard: occupancy decides in_ready; the oldest beat reaches the output STAGES cycles after accept.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_ir = (q.size() < STAGES) || out_ready;
            exp_ov = (q.size() > 0) && (cyc >= q[0].t + STAGES);
            chk("in_ready", 32'(in_ready), 32'(exp_ir));
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            chk("tx_count", 32'(tx_count), 32'(cnt % (1 << CNT_W)));
            if (exp_ov) begin
                chk("y", 32'(y), 32'(q[0].y));
                chk("zero", 32'(zero), 32'(q[0].y == '0));
`ifdef GATE_ARRAY_PARITY_EN
                chk("parity", 32'(parity), 32'(^q[0].y));
`endif
            end else begin
                chk("zero_idle", 32'(zero), 32'd0);
            end
            if (!rst) begin
                if (exp_ov && out_ready) begin
                    e = q.pop_front();
                    cnt++;
                    if (e.lit_en) begin
                        chk("lit_y", 32'(e.y), 32'(e.lit));
                        chk("lit_latency", 32'(cyc - e.t), 32'(STAGES));
                    end
                end
                if (in_valid && exp_ir) begin
                    e.y      = model_f(op, a, b);
                    e.t      = cyc;
                    e.lit_en = lit_en;
                    e.lit    = lit_val;
                    q.push_back(e);
                end
            end
        end
        if (rst) begin
            q.delete();
            cnt    = 0;
            chk_en = 1'b1;
        end
        cyc++;
    end

    task automatic beat(input logic [2:0] o, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
        int n;
        op = o; a = aa; b = bb; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) chk("beat_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lit_en   = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_ops [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                                4'b0110, 4'b1001, 4'b0011, 4'b1100};
    logic [2:0] bp_op [5] = '{3'b000, 3'b100, 3'b001, 3'b110, 3'b011};
    logic [3:0] bp_a  [5] = '{4'b1111, 4'b1010, 4'b0001, 4'b0110, 4'b0100};
    logic [3:0] bp_b  [5] = '{4'b0011, 4'b0110, 4'b1000, 4'b0000, 4'b0001};

    initial begin
        int acc;
        int idx;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_y", 32'(y), 32'd0);
        chk("reset_tx_count", 32'(tx_count), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // All ops on a=1100 b=1010 with literal results and latency.
        out_ready = 1'b1;
        for (int o = 0; o < 8; o++) begin
            lit_en  = 1'b1;
            lit_val = exp_ops[o];
            beat(3'(o), 4'b1100, 4'b1010);
        end
        idle(4);

        // Zero flag.
        lit_en  = 1'b1;
        lit_val = 4'b0000;
        beat(3'b000, 4'b0101, 4'b1010);
        @(negedge clk);
        @(negedge clk);
        chk("zero_flag", 32'(zero), 32'd1);
        chk("zero_y", 32'(y), 32'd0);
        @(posedge clk); #1;
        idle(3);

`ifdef GATE_ARRAY_PARITY_EN
        beat(3'b100, 4'b0111, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        chk("parity_lit", 32'(parity), 32'd1);
        chk("parity_y", 32'(y), 32'h7);
        @(posedge clk); #1;
        idle(3);
`endif

        // Backpressure: 4 stalled cycles with a 5-beat stream.
        out_ready = 1'b0;
        acc = 0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            op = bp_op[idx]; a = bp_a[idx]; b = bp_b[idx]; in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                acc++;
                idx++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd2);
        @(negedge clk);
        chk("bp_hold_y", 32'(y), 32'h3);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        while (idx < 5) begin
            beat(bp_op[idx], bp_a[idx], bp_b[idx]);
            idx++;
        end
        idle(5);

        // Mid-stream reset with two beats in flight.
        out_ready = 1'b0;
        beat(3'b001, 4'b0011, 4'b0100);
        beat(3'b111, 4'b1001, 4'b0000);
        do_reset();
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_y", 32'(y), 32'd0);
        chk("midrst_tx_count", 32'(tx_count), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        idle(6);

        // Counter wrap.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            beat(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
        end
        idle(4);
        @(negedge clk);
        chk("wrap_256", 32'(tx_count), 32'd0);
        @(posedge clk); #1;
        beat(3'b101, 4'b0000, 4'b1111);
        idle(4);
        @(negedge clk);
        chk("wrap_257", 32'(tx_count), 32'd1);
        @(posedge clk); #1;

        // Random traffic with random backpressure and rare resets.
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op        = 3'($urandom);
            a         = 4'($urandom);
            b         = 4'($urandom);
            rst       = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
